// File: rtl/video_sync_gen_if.sv
// Timing bundle between the raster generator and the video output stage.
// The master side is the generator; the slave side consumes the timing.
interface video_sync_gen_if;
   logic       cen;
   logic       cfg_vsel;
   logic [8:0] hcount;
   logic [8:0] vcount;
   logic       hblank;
   logic       vblank;
   logic       hpix;
   logic       vpix;
   logic       hsync;
   logic       vsync;
   logic       vga_hsync;
   logic       hsync_start;
   logic       scanin_start;
   logic       scanout_start;
   logic       line_start;
   logic       frame_start;

   modport master (
      input  cen, cfg_vsel,
      output hcount, vcount, hblank, vblank, hpix, vpix, hsync, vsync, vga_hsync,
      output hsync_start, scanin_start, scanout_start, line_start, frame_start
   );

   modport slave (
      output cen, cfg_vsel,
      input  hcount, vcount, hblank, vblank, hpix, vpix, hsync, vsync, vga_hsync,
      input  hsync_start, scanin_start, scanout_start, line_start, frame_start
   );
endinterface

// File: rtl/video_sync_gen.sv
// Raster timing generator: dot/line counters with registered, zero-lag blanking, sync,
// pixel-window and scan-doubler strobes decoded from the next counter state.
module video_sync_gen #(
   parameter int unsigned HTotal    = 448,
   parameter int unsigned HBlankEnd = 88,
   parameter int unsigned HSyncBeg  = 16,
   parameter int unsigned HSyncEnd  = 48,
   parameter int unsigned HPixBeg   = 152,
   parameter int unsigned HPixEnd   = 408,
   parameter int unsigned VgaHsBeg  = 8,
   parameter int unsigned VgaHsEnd  = 24,
   parameter int unsigned VTotalA   = 320,
   parameter int unsigned VTotalB   = 312,
   parameter int unsigned VBlankEnd = 32,
   parameter int unsigned VSyncBeg  = 8,
   parameter int unsigned VSyncEnd  = 12,
   parameter int unsigned VPixBeg   = 80,
   parameter int unsigned VPixEnd   = 272
) (
   input  logic                clk,
   input  logic                rst_n,
   video_sync_gen_if.master    vid_io
);

   localparam logic [8:0] HLast      = 9'(HTotal - 1);
   localparam logic [8:0] HHalf      = 9'(HTotal / 2);
   localparam logic [8:0] HBlankEndC = 9'(HBlankEnd);
   localparam logic [8:0] HSyncBegC  = 9'(HSyncBeg);
   localparam logic [8:0] HSyncEndC  = 9'(HSyncEnd);
   localparam logic [8:0] HPixBegC   = 9'(HPixBeg);
   localparam logic [8:0] HPixEndC   = 9'(HPixEnd);
   localparam logic [8:0] VgaHsBegC  = 9'(VgaHsBeg);
   localparam logic [8:0] VgaHsEndC  = 9'(VgaHsEnd);
   localparam logic [8:0] VTotA      = 9'(VTotalA);
   localparam logic [8:0] VTotB      = 9'(VTotalB);
   localparam logic [8:0] VBlankEndC = 9'(VBlankEnd);
   localparam logic [8:0] VSyncBegC  = 9'(VSyncBeg);
   localparam logic [8:0] VSyncEndC  = 9'(VSyncEnd);
   localparam logic [8:0] VPixBegC   = 9'(VPixBeg);
   localparam logic [8:0] VPixEndC   = 9'(VPixEnd);

   typedef struct packed {
      logic hblank;
      logic vblank;
      logic hpix;
      logic vpix;
      logic hsync;
      logic vsync;
      logic vga_hsync;
   } levels_t;

   typedef struct packed {
      logic hsync_start;
      logic scanin_start;
      logic scanout_start;
      logic line_start;
      logic frame_start;
   } pulses_t;

   logic       cen;
   logic       cfg_vsel;
   logic [8:0] hcount_q, hcount_d;
   logic [8:0] vcount_q, vcount_d;
   logic [8:0] vtotal_q, vtotal_d;
   logic       h_wrap;
   logic       v_wrap;
   logic [8:0] hhalf_pos;
   levels_t    lvl_q, lvl_d;
   pulses_t    pls_q, pls_d;

   assign cen      = vid_io.cen;
   assign cfg_vsel = vid_io.cfg_vsel;

   // Counter next state; frame length is only re-latched at the frame wrap.
   always_comb begin
      h_wrap   = (hcount_q == HLast);
      v_wrap   = (vcount_q == vtotal_q - 9'd1);
      hcount_d = hcount_q;
      vcount_d = vcount_q;
      vtotal_d = vtotal_q;
      if (cen) begin
         hcount_d = h_wrap ? 9'd0 : hcount_q + 9'd1;
         if (h_wrap) begin
            vcount_d = v_wrap ? 9'd0 : vcount_q + 9'd1;
            if (v_wrap) begin
               vtotal_d = cfg_vsel ? VTotB : VTotA;
            end
         end
      end
   end

   // Decode from the next counter values so registered levels line up with hcount/vcount.
   always_comb begin
      hhalf_pos       = (hcount_d >= HHalf) ? hcount_d - HHalf : hcount_d;
      lvl_d           = '0;
      lvl_d.hblank    = (hcount_d < HBlankEndC);
      lvl_d.vblank    = (vcount_d < VBlankEndC);
      lvl_d.hpix      = (hcount_d >= HPixBegC) && (hcount_d < HPixEndC);
      lvl_d.vpix      = (vcount_d >= VPixBegC) && (vcount_d < VPixEndC);
      lvl_d.hsync     = (hcount_d >= HSyncBegC) && (hcount_d < HSyncEndC);
      lvl_d.vsync     = (vcount_d >= VSyncBegC) && (vcount_d < VSyncEndC);
      lvl_d.vga_hsync = (hhalf_pos >= VgaHsBegC) && (hhalf_pos < VgaHsEndC);
   end

   // Strobes fire only on a cen edge, so they self-clear on the following clock.
   always_comb begin
      pls_d = '0;
      if (cen) begin
         pls_d.hsync_start   = (hcount_d == HSyncBegC);
         pls_d.scanin_start  = (hcount_d == HBlankEndC);
         pls_d.scanout_start = (hcount_d == 9'd0) || (hcount_d == HHalf);
         pls_d.line_start    = (hcount_d == 9'd0);
         pls_d.frame_start   = (hcount_d == 9'd0) && (vcount_d == 9'd0);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hcount_q <= HLast;
         vcount_q <= VTotA - 9'd1;
         vtotal_q <= VTotA;
         lvl_q    <= '0;
         pls_q    <= '0;
      end else begin
         hcount_q <= hcount_d;
         vcount_q <= vcount_d;
         vtotal_q <= vtotal_d;
         pls_q    <= pls_d;
         if (cen) begin
            lvl_q <= lvl_d;
         end
      end
   end

   assign vid_io.hcount        = hcount_q;
   assign vid_io.vcount        = vcount_q;
   assign vid_io.hblank        = lvl_q.hblank;
   assign vid_io.vblank        = lvl_q.vblank;
   assign vid_io.hpix          = lvl_q.hpix;
   assign vid_io.vpix          = lvl_q.vpix;
   assign vid_io.hsync         = lvl_q.hsync;
   assign vid_io.vsync         = lvl_q.vsync;
   assign vid_io.vga_hsync     = lvl_q.vga_hsync;
   assign vid_io.hsync_start   = pls_q.hsync_start;
   assign vid_io.scanin_start  = pls_q.scanin_start;
   assign vid_io.scanout_start = pls_q.scanout_start;
   assign vid_io.line_start    = pls_q.line_start;
   assign vid_io.frame_start   = pls_q.frame_start;

endmodule

// File: tb/tb_video_sync_gen.sv
// Scoreboard bench for video_sync_gen: full horizontal timing with a shortened vertical
// raster (20/18 lines) so whole frames fit in a short run.
module tb_video_sync_gen;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic probe = 1'b0;

   video_sync_gen_if vif ();

   video_sync_gen #(
      .VTotalA   (20),
      .VTotalB   (18),
      .VBlankEnd (4),
      .VSyncBeg  (1),
      .VSyncEnd  (2),
      .VPixBeg   (6),
      .VPixEnd   (14)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .vid_io (vif)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      bit          is_frame;
      logic [8:0]  h;
      logic [8:0]  v;
      logic [4:0]  pls;
      logic [6:0]  lvl;
      bit          chk_lper;
      int unsigned lper;
      bit          chk_stats;
      int unsigned period;
      int unsigned pix;
      int unsigned vmax;
   } exp_t;

   exp_t        exp_q[$];
   int          vectors     = 0;
   int          miscompares = 0;
   int unsigned gap         = 0;

   int unsigned clk_cnt   = 0;
   int unsigned cen_cnt   = 0;
   int unsigned pix_cnt   = 0;
   int unsigned vmax_run  = 0;
   int unsigned lper_meas = 0;
   int unsigned f_period  = 0;
   int unsigned f_pix     = 0;
   int unsigned f_vmax    = 0;

   // {hsync_start, scanin_start, scanout_start, line_start, frame_start}
   function automatic logic [4:0] act_pls();
      return {vif.hsync_start, vif.scanin_start, vif.scanout_start, vif.line_start,
              vif.frame_start};
   endfunction

   // {hblank, vblank, hpix, vpix, hsync, vsync, vga_hsync}
   function automatic logic [6:0] act_lvl();
      return {vif.hblank, vif.vblank, vif.hpix, vif.vpix, vif.hsync, vif.vsync, vif.vga_hsync};
   endfunction

   task automatic push_snap(input string name, input int h, input int v, input logic [4:0] p,
                            input logic [6:0] l, input int unsigned lper);
      exp_t e;
      e.name      = name;
      e.is_frame  = 1'b0;
      e.h         = 9'(h);
      e.v         = 9'(v);
      e.pls       = p;
      e.lvl       = l;
      e.chk_lper  = (lper != 0);
      e.lper      = lper;
      e.chk_stats = 1'b0;
      e.period    = 0;
      e.pix       = 0;
      e.vmax      = 0;
      exp_q.push_back(e);
   endtask

   task automatic push_frame(input string name, input int unsigned lper,
                             input int unsigned period, input int unsigned pix,
                             input int unsigned vmax);
      exp_t e;
      e.name      = name;
      e.is_frame  = 1'b1;
      e.h         = 9'd0;
      e.v         = 9'd0;
      e.pls       = 5'b00111;
      e.lvl       = 7'b1100000;
      e.chk_lper  = (lper != 0);
      e.lper      = lper;
      e.chk_stats = (period != 0);
      e.period    = period;
      e.pix       = pix;
      e.vmax      = vmax;
      exp_q.push_back(e);
   endtask

   task automatic check(input bit is_frame);
      exp_t e;
      bit   bad;
      vectors++;
      if (exp_q.size() == 0) begin
         miscompares++;
         $display("FAIL unexpected_%s: got h=%0d v=%0d pulses=%b, required no event",
                  is_frame ? "frame" : "probe", vif.hcount, vif.vcount, act_pls());
         return;
      end
      e   = exp_q.pop_front();
      bad = (e.is_frame != is_frame) || (vif.hcount !== e.h) || (vif.vcount !== e.v) ||
            (act_pls() !== e.pls) || (act_lvl() !== e.lvl);
      if (e.chk_lper && (lper_meas != e.lper)) bad = 1'b1;
      if (e.chk_stats && ((f_period != e.period) || (f_pix != e.pix) || (f_vmax != e.vmax)))
         bad = 1'b1;
      if (bad) begin
         miscompares++;
         $display({"FAIL %s: got frame=%0b h=%0d v=%0d pulses=%b levels=%b lper=%0d ",
                   "period=%0d pix=%0d vmax=%0d; required frame=%0b h=%0d v=%0d pulses=%b ",
                   "levels=%b lper=%0d period=%0d pix=%0d vmax=%0d"},
                  e.name, is_frame, vif.hcount, vif.vcount, act_pls(), act_lvl(), lper_meas,
                  f_period, f_pix, f_vmax, e.is_frame, e.h, e.v, e.pls, e.lvl, e.lper,
                  e.period, e.pix, e.vmax);
      end
   endtask

   // Monitor: frame_start pulses and probe requests each pop one expectation.
   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         #1;
         if (!rst_n) begin
            clk_cnt  = 0;
            cen_cnt  = 0;
            pix_cnt  = 0;
            vmax_run = 0;
         end else if (clk) begin
            clk_cnt++;
            if (vif.cen) begin
               cen_cnt++;
               if (vif.hpix && vif.vpix) pix_cnt++;
            end
            if (vif.line_start) begin
               lper_meas = clk_cnt;
               clk_cnt   = 0;
            end
            if (vif.frame_start) begin
               f_period = cen_cnt;
               f_pix    = pix_cnt;
               f_vmax   = vmax_run;
               cen_cnt  = 0;
               pix_cnt  = 0;
               vmax_run = 0;
               check(1'b1);
            end else if (32'(vif.vcount) > vmax_run) begin
               vmax_run = 32'(vif.vcount);
            end
         end
         if (probe) check(1'b0);
      end
   end

   task automatic tick(input bit c, input bit p);
      @(negedge clk);
      vif.cen = c;
      probe   = p;
   endtask

   task automatic run(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) begin
         repeat (gap) tick(1'b0, 1'b0);
         tick(1'b1, 1'b0);
      end
   endtask

   task automatic probe_cen(input string name, input int h, input int v, input logic [4:0] p,
                            input logic [6:0] l, input int unsigned lper);
      push_snap(name, h, v, p, l, lper);
      repeat (gap) tick(1'b0, 1'b0);
      tick(1'b1, 1'b1);
   endtask

   initial begin
      exp_t e;
      vif.cen      = 1'b0;
      vif.cfg_vsel = 1'b0;

      // Reset state and quiet release
      repeat (3) tick(1'b0, 1'b0);
      push_snap("reset_state", 447, 19, 5'b00000, 7'b0000000, 0);
      tick(1'b0, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;
      probe = 1'b0;
      push_snap("idle_after_release", 447, 19, 5'b00000, 7'b0000000, 0);
      tick(1'b0, 1'b1);

      // First cen wraps both counters
      push_frame("first_frame", 0, 0, 0, 0);
      push_snap("first_cen", 0, 0, 5'b00111, 7'b1100000, 0);
      tick(1'b1, 1'b1);
      push_snap("held_cen_pulse_clear", 1, 0, 5'b00000, 7'b1100000, 0);
      tick(1'b1, 1'b1);
      push_snap("idle_hold", 1, 0, 5'b00000, 7'b1100000, 0);
      tick(1'b0, 1'b1);

      // Horizontal decode with cen every second clock
      gap = 1;
      run(6);   probe_cen("vga_on",      8,   0, 5'b00000, 7'b1100001, 0);
      run(7);   probe_cen("hsync_start", 16,  0, 5'b10000, 7'b1100101, 0);
      run(7);   probe_cen("vga_off",     24,  0, 5'b00000, 7'b1100100, 0);
      run(23);  probe_cen("hsync_off",   48,  0, 5'b00000, 7'b1100000, 0);
      run(39);  probe_cen("scanin",      88,  0, 5'b01000, 7'b0100000, 0);
      run(63);  probe_cen("hpix_on",     152, 0, 5'b00000, 7'b0110000, 0);
      run(71);  probe_cen("scanout_mid", 224, 0, 5'b00100, 7'b0110000, 0);
      run(7);   probe_cen("vga2_on",     232, 0, 5'b00000, 7'b0110001, 0);
      run(14);  probe_cen("vga2_last",   247, 0, 5'b00000, 7'b0110001, 0);
                probe_cen("vga2_off",    248, 0, 5'b00000, 7'b0110000, 0);
      run(159); probe_cen("hpix_off",    408, 0, 5'b00000, 7'b0100000, 0);
      run(39);  probe_cen("line1_vsync", 0,   1, 5'b00110, 7'b1100010, 0);
      run(447); probe_cen("line_period", 0,   2, 5'b00110, 7'b1100000, 896);

      // Full frame at cfg_vsel=0
      gap = 0;
      push_frame("frame_len_a", 448, 8960, 2048, 19);
      run(8064);

      // cfg_vsel rises mid-frame: current frame keeps 20 lines, next has 18
      run(4480);
      vif.cfg_vsel = 1'b1;
      push_frame("frame_vsel_mid", 448, 8960, 2048, 19);
      run(4480);
      run(2240);
      vif.cfg_vsel = 1'b0;
      push_frame("frame_len_b", 448, 8064, 2048, 17);
      run(5824);
      run(8063);
      probe_cen("no_wrap_at_18", 0, 18, 5'b00110, 7'b1000000, 0);

      // cen held low for 50 clocks inside hsync
      run(19);
      probe_cen("hsync_at20", 20, 18, 5'b00000, 7'b1000101, 0);
      repeat (49) tick(1'b0, 1'b0);
      push_snap("hold_50", 20, 18, 5'b00000, 7'b1000101, 0);
      tick(1'b0, 1'b1);

      // Asynchronous reset mid-frame
      run(727);
      probe_cen("pre_reset", 300, 19, 5'b00000, 7'b0010000, 0);
      push_snap("async_reset", 447, 19, 5'b00000, 7'b0000000, 0);
      @(negedge clk);
      vif.cen = 1'b0;
      probe   = 1'b1;
      #2 rst_n = 1'b0;
      #2 probe = 1'b0;
      repeat (3) tick(1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      tick(1'b0, 1'b0);
      push_frame("frame_after_reset", 0, 0, 0, 0);
      push_snap("first_cen_after_reset", 0, 0, 5'b00111, 7'b1100000, 0);
      tick(1'b1, 1'b1);
      repeat (3) tick(1'b0, 1'b0);

      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         vectors++;
         miscompares++;
         $display("FAIL %s: got no event, required h=%0d v=%0d pulses=%b", e.name, e.h, e.v,
                  e.pls);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
